// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounces five push-buttons and sequences EN/load/preset and lap-freeze for the counter chain.
// Optional build macro STOP_AT_MAX_EN: pause with a one-cycle ovf pulse when the live count reaches 59:59.99.
module stopwatch_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned LOAD_HOLD  = 100000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic        clk_50Mhz,
    input  logic        rst,
    input  logic        key_start,
    input  logic        key_pause,
    input  logic        key_load,
    input  logic        key_lap,
    input  logic        key_clear,
    input  logic [23:0] preset_in,
    input  logic [23:0] dispbuf_in,
    output logic        EN,
    output logic        load,
    output logic [23:0] preset,
    output logic [23:0] dispbuf_out,
    output logic [1:0]  state,
    output logic        lap_active,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_PAUSED = 2'b10,
        S_LOAD   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOAD_HOLD - 1);

    // Key bit order: 0 start, 1 pause, 2 load, 3 lap, 4 clear
    logic [4:0] keys_raw;
    logic [4:0] press;

    assign keys_raw = {key_clear, key_lap, key_load, key_pause, key_start};

    for (genvar k = 0; k < 5; k++) begin : g_key
        logic             sync1_q;
        logic             sync2_q;
        logic             deb_q;
        logic             press_q;
        logic [CNT_W-1:0] cnt_q;

        // A level is accepted only after DEB_CYCLES consecutive differing samples; any bounce restarts the run.
        always_ff @(posedge clk_50Mhz or negedge rst) begin
            if (!rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                deb_q   <= 1'b0;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= keys_raw[k];
                sync2_q <= sync1_q;
                press_q <= 1'b0;
                if (sync2_q == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_q   <= '0;
                    deb_q   <= sync2_q;
                    press_q <= sync2_q;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign press[k] = press_q;
    end

    logic ev_start;
    logic ev_pause;
    logic ev_load;
    logic ev_lap;
    logic ev_clear;

    assign ev_clear = press[4];
    assign ev_load  = press[2] & ~press[4];
    assign ev_start = press[0] & ~press[2] & ~press[4];
    assign ev_pause = press[1] & ~press[0] & ~press[2] & ~press[4];
    assign ev_lap   = press[3] & ~press[0] & ~press[1] & ~press[2] & ~press[4];

    logic max_hit;

`ifdef STOP_AT_MAX_EN
    logic at_max;
    logic at_max_q;

    // Fire only on arrival at the maximum so a resume from PAUSED at 59:59.99 is allowed to wrap.
    assign at_max  = (dispbuf_in == 24'h595999);
    assign max_hit = at_max & ~at_max_q;

    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            at_max_q <= 1'b0;
        end else begin
            at_max_q <= at_max;
        end
    end
`else
    assign max_hit = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [23:0]      preset_q, preset_d;
    logic [23:0]      lap_q, lap_d;
    logic             lap_act_q, lap_act_d;
    logic             en_q, en_d;
    logic             load_q, load_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        preset_d  = preset_q;
        lap_d     = lap_q;
        lap_act_d = lap_act_q;
        ovf_d     = 1'b0;

        case (state_q)
            S_IDLE, S_PAUSED: begin
                if (ev_clear) begin
                    state_d  = S_LOAD;
                    preset_d = '0;
                end else if (ev_load) begin
                    state_d  = S_LOAD;
                    preset_d = preset_in;
                end else if (ev_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ev_clear) begin
                    state_d  = S_LOAD;
                    preset_d = '0;
                end else if (ev_pause) begin
                    state_d = S_PAUSED;
                end else if (max_hit) begin
                    state_d = S_PAUSED;
                    ovf_d   = 1'b1;
                end
            end
            S_LOAD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_PAUSED;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ev_lap && state_q != S_LOAD) begin
            if (lap_act_q) begin
                lap_act_d = 1'b0;
            end else if (state_q == S_RUN) begin
                lap_d     = dispbuf_in;
                lap_act_d = 1'b1;
            end
        end

        if (state_d == S_LOAD && state_q != S_LOAD) begin
            lap_act_d = 1'b0;
            hold_d    = '0;
        end

        // EN and load decode the next state so they toggle on the same edge as the state register.
        en_d   = (state_d == S_RUN);
        load_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            preset_q  <= '0;
            lap_q     <= '0;
            lap_act_q <= 1'b0;
            en_q      <= 1'b0;
            load_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            preset_q  <= preset_d;
            lap_q     <= lap_d;
            lap_act_q <= lap_act_d;
            en_q      <= en_d;
            load_q    <= load_d;
            ovf_q     <= ovf_d;
        end
    end

    assign state       = state_q;
    assign EN          = en_q;
    assign load        = load_q;
    assign preset      = preset_q;
    assign lap_active  = lap_act_q;
    assign ovf         = ovf_q;
    assign dispbuf_out = lap_act_q ? lap_q : dispbuf_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with short debounce/hold: a behavioural model checked every cycle plus literal expectations.
module tb_stopwatch_ctrl;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam logic [1:0] M_IDLE   = 2'b00;
  localparam logic [1:0] M_RUN    = 2'b01;
  localparam logic [1:0] M_PAUSED = 2'b10;
  localparam logic [1:0] M_LOAD   = 2'b11;
  localparam logic [23:0] MAXV = 24'h595999;

  logic        clk_50Mhz = 1'b0;
  logic        rst;
  logic        key_start, key_pause, key_load, key_lap, key_clear;
  logic [23:0] preset_in, dispbuf_in;
  logic        EN, load, lap_active, ovf;
  logic [23:0] preset, dispbuf_out;
  logic [1:0]  state;

  always #10 clk_50Mhz = ~clk_50Mhz;

  stopwatch_ctrl #(.DEB_CYCLES(DEB), .LOAD_HOLD(HOLD), .CNT_W(20)) dut (
    .clk_50Mhz  (clk_50Mhz),
    .rst        (rst),
    .key_start  (key_start),
    .key_pause  (key_pause),
    .key_load   (key_load),
    .key_lap    (key_lap),
    .key_clear  (key_clear),
    .preset_in  (preset_in),
    .dispbuf_in (dispbuf_in),
    .EN         (EN),
    .load       (load),
    .preset     (preset),
    .dispbuf_out(dispbuf_out),
    .state      (state),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0]  hist[$];
  logic [4:0]  m_deb = '0;
  logic [4:0]  m_pend = '0;
  logic [4:0]  m_ev;
  logic [1:0]  m_state = M_IDLE;
  logic [23:0] m_preset = '0;
  logic [23:0] m_lap_reg = '0;
  logic        m_lap_act = 1'b0;
  logic        m_ovf = 1'b0;
  int          m_left = 0;
  logic        m_stable;
  logic [4:0]  m_smp;
`ifdef STOP_AT_MAX_EN
  logic        m_prev_max = 1'b0;
`endif

  function automatic logic [4:0] back(input int b);
    if (b < hist.size()) return hist[hist.size() - 1 - b];
    return 5'b0;
  endfunction

  always @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      hist.delete();
      m_deb = '0; m_pend = '0; m_state = M_IDLE; m_preset = '0;
      m_lap_reg = '0; m_lap_act = 1'b0; m_ovf = 1'b0; m_left = 0;
`ifdef STOP_AT_MAX_EN
      m_prev_max = 1'b0;
`endif
    end else begin
      m_ev = m_pend;
      m_pend = '0;
      hist.push_back({key_clear, key_lap, key_load, key_pause, key_start});
      if (hist.size() > 16) void'(hist.pop_front());
      // a key level is accepted once the synchronised samples disagree with it DEB times in a row
      for (int k = 0; k < 5; k++) begin
        m_stable = 1'b1;
        for (int b = 2; b <= DEB + 1; b++) begin
          m_smp = back(b);
          if (m_smp[k] == m_deb[k]) m_stable = 1'b0;
        end
        if (m_stable) begin
          m_deb[k] = ~m_deb[k];
          if (m_deb[k]) m_pend[k] = 1'b1;
        end
      end
      // priority clear > load > start > pause > lap
      if (m_ev[4]) m_ev = 5'b10000;
      else if (m_ev[2]) m_ev = 5'b00100;
      else if (m_ev[0]) m_ev = 5'b00001;
      else if (m_ev[1]) m_ev = 5'b00010;
      m_ovf = 1'b0;
      if (m_ev == 5'b01000 && m_state != M_LOAD) begin
        if (m_lap_act) m_lap_act = 1'b0;
        else if (m_state == M_RUN) begin
          m_lap_reg = dispbuf_in;
          m_lap_act = 1'b1;
        end
      end
      case (m_state)
        M_IDLE, M_PAUSED: begin
          if (m_ev[4] || m_ev[2]) begin
            m_preset = m_ev[4] ? 24'h0 : preset_in;
            m_state = M_LOAD; m_lap_act = 1'b0; m_left = HOLD;
          end else if (m_ev[0]) m_state = M_RUN;
        end
        M_RUN: begin
          if (m_ev[4]) begin
            m_preset = 24'h0; m_state = M_LOAD; m_lap_act = 1'b0; m_left = HOLD;
          end else if (m_ev[1]) m_state = M_PAUSED;
`ifdef STOP_AT_MAX_EN
          else if (dispbuf_in == MAXV && !m_prev_max) begin
            m_state = M_PAUSED; m_ovf = 1'b1;
          end
`endif
        end
        default: begin
          m_left--;
          if (m_left == 0) m_state = M_PAUSED;
        end
      endcase
`ifdef STOP_AT_MAX_EN
      m_prev_max = (dispbuf_in == MAXV);
`endif
    end
  end

  // every-cycle comparison of all outputs against the model
  logic [53:0] exp_v, act_v;
  always @(negedge clk_50Mhz) begin
    exp_v = {m_state, m_state == M_RUN, m_state == M_LOAD, m_lap_act, m_ovf, m_preset,
             m_lap_act ? m_lap_reg : dispbuf_in};
    act_v = {state, EN, load, lap_active, ovf, preset, dispbuf_out};
    check("cycle_outputs", 64'(act_v), 64'(exp_v));
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk_50Mhz);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // hold keys for 6 cycles, release, and return just after the edge where the event acts
  task automatic press(input logic [4:0] m);
    {key_clear, key_lap, key_load, key_pause, key_start} = m;
    repeat (6) tick();
    {key_clear, key_lap, key_load, key_pause, key_start} = 5'b0;
    tick();
  endtask

  int n;

  initial begin
    rst = 1'b0;
    {key_clear, key_lap, key_load, key_pause, key_start} = 5'b0;
    preset_in = 24'h0;
    dispbuf_in = 24'h0;
    idle(3);
    check("reset_state", 64'(state), 64'(2'b00));
    check("reset_en_load", 64'({EN, load}), 64'(2'b00));
    check("reset_preset", 64'(preset), 64'(24'h0));
    check("reset_lap_ovf", 64'({lap_active, ovf}), 64'(2'b00));
    rst = 1'b1;

    // 3-cycle glitch must not be accepted
    key_start = 1'b1;
    idle(3);
    key_start = 1'b0;
    idle(12);
    check("glitch_ignored", 64'(state), 64'(2'b00));

    // start: state changes on edge 2+DEB+1 = 7
    key_start = 1'b1;
    idle(6);
    check("start_edge6_idle", 64'(state), 64'(2'b00));
    key_start = 1'b0;
    tick();
    check("start_edge7_run", 64'({state, EN}), 64'({2'b01, 1'b1}));
    idle(8);

    // lap freeze and release
    dispbuf_in = 24'h011234;
    press(5'b01000);
    check("lap_on", 64'(lap_active), 64'(1'b1));
    dispbuf_in = 24'h011300;
    #1;
    check("lap_frozen", 64'(dispbuf_out), 64'(24'h011234));
    idle(8);
    press(5'b01000);
    check("lap_off", 64'({lap_active, dispbuf_out}), 64'({1'b0, 24'h011300}));
    idle(8);

    // count reaches maximum while running
    dispbuf_in = MAXV;
    tick();
`ifdef STOP_AT_MAX_EN
    check("max_pause", 64'({state, EN, ovf}), 64'({2'b10, 1'b0, 1'b1}));
    tick();
    check("max_ovf_pulse", 64'(ovf), 64'(1'b0));
    press(5'b00001);
    check("max_resume", 64'(state), 64'(2'b01));
    tick();
    check("max_resume_holds", 64'({state, ovf}), 64'({2'b01, 1'b0}));
`else
    check("max_no_stop", 64'({state, ovf}), 64'({2'b01, 1'b0}));
    tick();
    check("max_no_stop_next", 64'({state, ovf}), 64'({2'b01, 1'b0}));
`endif
    dispbuf_in = 24'h0;
    idle(8);

    press(5'b00010);
    check("pause", 64'({state, EN}), 64'({2'b10, 1'b0}));
    idle(8);

    // load preset from PAUSED, load held exactly HOLD cycles
    preset_in = 24'h123456;
    press(5'b00100);
    check("load_enter", 64'({state, load, EN}), 64'({2'b11, 1'b1, 1'b0}));
    check("load_preset", 64'(preset), 64'(24'h123456));
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!load) break;
      n++;
    end
    check("load_hold_cycles", 64'(n), 64'(HOLD));
    check("load_exit", 64'({state, EN, preset}), 64'({2'b10, 1'b0, 24'h123456}));
    idle(8);

    // start and clear together in RUN with lap active: clear wins and drops lap
    press(5'b00001);
    check("run_again", 64'(state), 64'(2'b01));
    idle(8);
    dispbuf_in = 24'h000777;
    press(5'b01000);
    check("lap_before_clear", 64'(lap_active), 64'(1'b1));
    idle(8);
    press(5'b10001);
    check("clear_wins", 64'({state, preset, lap_active}), 64'({2'b11, 24'h0, 1'b0}));
    idle(8);
    check("clear_to_paused", 64'({state, load}), 64'({2'b10, 1'b0}));
    idle(4);

    // asynchronous reset in the middle of LOAD
    press(5'b00100);
    check("load_again", 64'({state, preset}), 64'({2'b11, 24'h123456}));
    idle(2);
    #5;
    rst = 1'b0;
    #1;
    check("reset_mid_load", 64'({state, load, EN, preset}), 64'({2'b00, 1'b0, 1'b0, 24'h0}));
    tick();
    rst = 1'b1;
    idle(4);
    check("idle_after_reset", 64'(state), 64'(2'b00));

    // clear from IDLE loads zero then pauses
    press(5'b10000);
    check("idle_clear", 64'({state, preset}), 64'({2'b11, 24'h0}));
    idle(10);
    check("idle_clear_done", 64'(state), 64'(2'b10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
